// File: rtl/cache_definition.sv
// Shared cache <-> memory types and constants used by the cache controllers,
// the memory arbiter and the ram32 controller.
package cache_definition;

   // Default watchdog budget for a granted transaction waiting on memory ready.
   localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

   typedef struct packed {
      logic        valid;
      logic        rw;
      logic [31:0] addr;
      logic [31:0] data;
   } cache_to_mem_type;

   typedef struct packed {
      logic        ready;
      logic [31:0] data;
   } mem_to_cache_type;

   typedef enum logic [1:0] {
      IDLE,
      GRANT0,
      GRANT1
   } arb_state_type;

   // Watchdog width: enough to hold the threshold, never narrower than 8 bits.
   function automatic int unsigned wdog_width(input int unsigned timeout);
      int unsigned w;
      w = $clog2(timeout + 1);
      return (w < 8) ? 8 : w;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin pick: a lone requester wins, a tie goes to rr_ptr_i.
module rr_arbiter2 (
   input  logic valid0_i,
   input  logic valid1_i,
   input  logic rr_ptr_i,
   output logic gnt_valid_o,
   output logic gnt_idx_o
);

   // Combinational winner selection.
   always_comb begin
      gnt_valid_o = valid0_i | valid1_i;
      gnt_idx_o   = (valid0_i & valid1_i) ? rr_ptr_i : valid1_i;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the I-cache and D-cache request ports onto the single ram32
// controller port, with round-robin fairness and a per-grant watchdog.
module mem_arbiter
   import cache_definition::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  cache_to_mem_type req0_to_mem,
   input  cache_to_mem_type req1_to_mem,
   output mem_to_cache_type mem_to_req0,
   output mem_to_cache_type mem_to_req1,
   output cache_to_mem_type arb_to_mem,
   input  mem_to_cache_type mem_to_arb,
   output logic             timeout_err
);

   localparam int unsigned CntW = wdog_width(TIMEOUT_CYCLES);
   // Value the counter holds during the last permitted wait cycle.
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   arb_state_type   state_q, state_d;
   logic            rr_q, rr_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            terr_q, terr_d;

   logic gnt_valid, gnt_idx;
   logic cur_valid, cur_idx;

   rr_arbiter2 u_rr (
      .valid0_i    (req0_to_mem.valid),
      .valid1_i    (req1_to_mem.valid),
      .rr_ptr_i    (rr_q),
      .gnt_valid_o (gnt_valid),
      .gnt_idx_o   (gnt_idx)
   );

   // Next-state: grant selection, completion, protocol-drop and watchdog abort.
   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      cnt_d     = cnt_q;
      terr_d    = 1'b0;
      cur_idx   = (state_q == GRANT1);
      cur_valid = cur_idx ? req1_to_mem.valid : req0_to_mem.valid;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (gnt_valid) begin
               state_d = gnt_idx ? GRANT1 : GRANT0;
            end
         end
         GRANT0, GRANT1: begin
            if (!cur_valid) begin
               // Requester walked away: abandon without touching fairness.
               state_d = IDLE;
            end else if (mem_to_arb.ready) begin
               state_d = IDLE;
               rr_d    = ~cur_idx;
            end else if (cnt_q == CntLast) begin
               state_d = IDLE;
               rr_d    = ~cur_idx;
               terr_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output mux driven by the registered grant; everything idles at zero.
   always_comb begin
      arb_to_mem  = '0;
      mem_to_req0 = '0;
      mem_to_req1 = '0;
      unique case (state_q)
         GRANT0: begin
            arb_to_mem        = req0_to_mem;
            mem_to_req0.ready = mem_to_arb.ready & req0_to_mem.valid;
            mem_to_req0.data  = mem_to_arb.data;
         end
         GRANT1: begin
            arb_to_mem        = req1_to_mem;
            mem_to_req1.ready = mem_to_arb.ready & req1_to_mem.valid;
            mem_to_req1.data  = mem_to_arb.data;
         end
         default: ;
      endcase
   end

   assign timeout_err = terr_q;

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         rr_q    <= 1'b0;
         cnt_q   <= '0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
         terr_q  <= terr_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter against a transaction-level
// ownership model of the two requesters and the memory port.
module tb_mem_arbiter;
   import cache_definition::*;

   localparam int unsigned T = 4;

   logic             clk, rst;
   cache_to_mem_type req0_to_mem, req1_to_mem, arb_to_mem;
   mem_to_cache_type mem_to_req0, mem_to_req1, mem_to_arb;
   logic             timeout_err;

   mem_arbiter #(.TIMEOUT_CYCLES(T)) dut (
      .clk         (clk),
      .rst         (rst),
      .req0_to_mem (req0_to_mem),
      .req1_to_mem (req1_to_mem),
      .mem_to_req0 (mem_to_req0),
      .mem_to_req1 (mem_to_req1),
      .arb_to_mem  (arb_to_mem),
      .mem_to_arb  (mem_to_arb),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: who owns the memory port (-1 none), waits so far, fairness turn.
   int m_owner, m_wait, m_rr, m_lat;
   bit m_err;
   int mem_mode, fixed_lat;
   bit seen0, seen1, act0, act1;
   logic obs_valid, obs_terr, prev_valid;
   logic [31:0] obs_addr;
   logic [31:0] grant_log[$];

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = -1; m_wait = 0; m_rr = 0; m_err = 1'b0; m_lat = 0;
   endtask

   task automatic check_outputs();
      cache_to_mem_type e_arb;
      mem_to_cache_type e0, e1;
      e_arb = '0; e0 = '0; e1 = '0;
      if (m_owner == 0) begin
         e_arb    = req0_to_mem;
         e0.ready = mem_to_arb.ready & req0_to_mem.valid;
         e0.data  = mem_to_arb.data;
      end else if (m_owner == 1) begin
         e_arb    = req1_to_mem;
         e1.ready = mem_to_arb.ready & req1_to_mem.valid;
         e1.data  = mem_to_arb.data;
      end
      check_val("arb_to_mem", 128'(arb_to_mem), 128'(e_arb));
      check_val("mem_to_req0", 128'(mem_to_req0), 128'(e0));
      check_val("mem_to_req1", 128'(mem_to_req1), 128'(e1));
      check_val("timeout_err", 128'(timeout_err), 128'(m_err));
      seen0 = e0.ready;
      seen1 = e1.ready;
   endtask

   task automatic model_step();
      int own;
      bit v;
      if (!rst) begin
         model_reset();
         return;
      end
      m_err = 1'b0;
      own   = m_owner;
      if (own < 0) begin
         if (req0_to_mem.valid && req1_to_mem.valid) m_owner = m_rr;
         else if (req0_to_mem.valid) m_owner = 0;
         else if (req1_to_mem.valid) m_owner = 1;
         m_wait = 0;
         m_lat  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 5));
      end else begin
         v = (own == 1) ? req1_to_mem.valid : req0_to_mem.valid;
         if (!v) begin
            m_owner = -1;
         end else if (mem_to_arb.ready) begin
            m_owner = -1;
            m_rr    = 1 - own;
         end else if (m_wait + 1 == int'(T)) begin
            m_owner = -1;
            m_rr    = 1 - own;
            m_err   = 1'b1;
         end else begin
            m_wait++;
         end
      end
   endtask

   task automatic drive_mem();
      mem_to_arb.data = $urandom();
      case (mem_mode)
         1: mem_to_arb.ready = 1'b0;
         2: mem_to_arb.ready = 1'b1;
         default: mem_to_arb.ready = (m_owner >= 0) ? (m_wait >= m_lat)
                                                     : ($urandom_range(0, 3) == 0);
      endcase
   endtask

   // One clock: check at +4 after the edge, advance model, reach next edge +1.
   task automatic tick();
      #3;
      check_outputs();
      obs_valid = arb_to_mem.valid;
      obs_terr  = timeout_err;
      obs_addr  = arb_to_mem.addr;
      if (obs_valid && !prev_valid) grant_log.push_back(obs_addr);
      prev_valid = obs_valid;
      model_step();
      @(posedge clk);
      #1;
      if (seen0) act0 = 1'b0;
      if (seen1) act1 = 1'b0;
      drive_mem();
   endtask

   task automatic idle_ticks(input int n);
      req0_to_mem.valid = 1'b0;
      req1_to_mem.valid = 1'b0;
      act0 = 1'b0; act1 = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      logic [31:0] exp_order [4];
      int          cnt;
      exp_order = '{32'h100, 32'h200, 32'h100, 32'h200};
      rst = 1'b0;
      req0_to_mem = '0; req1_to_mem = '0; mem_to_arb = '0;
      act0 = 1'b0; act1 = 1'b0; prev_valid = 1'b0;
      mem_mode = 0; fixed_lat = -1;
      model_reset();
      #2;
      check_outputs();
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive_mem();

      // Both requesters continuously valid from the first cycle after reset.
      fixed_lat = 3;
      grant_log.delete();
      req0_to_mem = '{valid: 1'b1, rw: RW_READ, addr: 32'h100, data: 32'h0};
      req1_to_mem = '{valid: 1'b1, rw: RW_READ, addr: 32'h200, data: 32'h0};
      act0 = 1'b1; act1 = 1'b1;
      for (int i = 0; i < 80 && grant_log.size() < 4; i++) begin
         tick();
         if (!act0) begin act0 = 1'b1; req0_to_mem.data = $urandom(); end
         if (!act1) begin act1 = 1'b1; req1_to_mem.data = $urandom(); end
      end
      check_val("rr_grant_count", 128'(grant_log.size()), 128'(4));
      for (int i = 0; i < 4 && i < grant_log.size(); i++)
         check_val("rr_grant_order", 128'(grant_log[i]), 128'(exp_order[i]));
      idle_ticks(3);

      // Lone D-cache write.
      req1_to_mem = '{valid: 1'b1, rw: RW_WRITE, addr: 32'h00040, data: 32'hDEADBEEF};
      act1 = 1'b1;
      tick();
      #1;
      check_val("wr_valid", 128'(arb_to_mem.valid), 128'(1));
      check_val("wr_rw", 128'(arb_to_mem.rw), 128'(RW_WRITE));
      check_val("wr_addr", 128'(arb_to_mem.addr), 128'(32'h00040));
      check_val("wr_data", 128'(arb_to_mem.data), 128'(32'hDEADBEEF));
      check_val("wr_req0_ready", 128'(mem_to_req0.ready), 128'(0));
      for (int i = 0; i < 10 && act1; i++) begin
         tick();
         req1_to_mem.valid = act1;
      end
      check_val("wr_completed", 128'(act1), 128'(0));
      idle_ticks(2);

      // Watchdog: memory never answers.
      fixed_lat = -1; mem_mode = 1;
      drive_mem();
      req0_to_mem = '{valid: 1'b1, rw: RW_READ, addr: 32'h100, data: 32'h5};
      act0 = 1'b1;
      tick();
      req1_to_mem = '{valid: 1'b1, rw: RW_READ, addr: 32'h200, data: 32'h6};
      act1 = 1'b1;
      cnt = 0;
      obs_terr = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (obs_terr) break;
         if (obs_valid) cnt++;
      end
      check_val("to_seen", 128'(obs_terr), 128'(1));
      check_val("to_wait_cycles", 128'(cnt), 128'(T));
      tick();
      check_val("to_pulse_width", 128'(obs_terr), 128'(0));
      check_val("to_next_valid", 128'(obs_valid), 128'(1));
      check_val("to_next_port", 128'(obs_addr), 128'(32'h200));
      mem_mode = 0;
      idle_ticks(3);

      // Reset while granted to port 1.
      mem_mode = 1;
      drive_mem();
      req1_to_mem = '{valid: 1'b1, rw: RW_READ, addr: 32'h200, data: 32'h7};
      act1 = 1'b1;
      tick();
      mem_to_arb.ready = 1'b1;
      #1;
      rst = 1'b0;
      #1;
      check_val("rst_arb_valid", 128'(arb_to_mem.valid), 128'(0));
      check_val("rst_req1_ready", 128'(mem_to_req1.ready), 128'(0));
      check_val("rst_req1_data", 128'(mem_to_req1.data), 128'(0));
      model_reset();
      req0_to_mem = '{valid: 1'b1, rw: RW_READ, addr: 32'h100, data: 32'h8};
      act0 = 1'b1;
      tick();
      rst = 1'b1;
      mem_mode = 0; fixed_lat = 1;
      tick();
      tick();
      check_val("rst_first_grant", 128'(obs_addr), 128'(32'h100));
      idle_ticks(4);

      // Spurious memory ready while idle.
      mem_mode = 2;
      drive_mem();
      for (int i = 0; i < 3; i++) begin
         tick();
         #1;
         check_val("spur_req0_ready", 128'(mem_to_req0.ready), 128'(0));
         check_val("spur_req1_ready", 128'(mem_to_req1.ready), 128'(0));
         check_val("spur_arb_valid", 128'(arb_to_mem.valid), 128'(0));
      end

      // Random traffic including late/absent ready and abandoned requests.
      mem_mode = 0; fixed_lat = -1;
      idle_ticks(1);
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (act0 && $urandom_range(0, 63) == 0) act0 = 1'b0;
         else if (!act0 && $urandom_range(0, 2) == 0) begin
            act0 = 1'b1;
            req0_to_mem.rw   = 1'($urandom());
            req0_to_mem.addr = $urandom();
            req0_to_mem.data = $urandom();
         end
         if (act1 && $urandom_range(0, 63) == 0) act1 = 1'b0;
         else if (!act1 && $urandom_range(0, 2) == 0) begin
            act1 = 1'b1;
            req1_to_mem.rw   = 1'($urandom());
            req1_to_mem.addr = $urandom();
            req1_to_mem.data = $urandom();
         end
         req0_to_mem.valid = act0;
         req1_to_mem.valid = act1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
